// File: rtl/rtt_stamp.sv
// rtl/rtt_stamp.sv - overwrites one payload word of RTT probe frames with a cycle-count timestamp
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 0
`endif

module rtt_stamp #(
  parameter int                    DATA_WIDTH          = 64,
  parameter int                    CTRL_WIDTH          = DATA_WIDTH/8,
  parameter int                    UDP_REG_SRC_WIDTH   = 2,
  parameter int                    UDP_REG_ADDR_WIDTH  = 23,
  parameter int                    CPCI_NF2_DATA_WIDTH = 32,
  parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM  = `IO_QUEUE_STAGE_NUM,
  parameter logic [15:0]           STAMP_PORT_MASK     = 16'h0055,
  parameter logic [15:0]           PROBE_ETHERTYPE     = 16'h88B5,
  parameter int                    STAMP_WORD          = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic                           in_wr,
  output logic                           in_rdy,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out
);

  localparam int DST_POS = `IOQ_DST_PORT_POS;
  localparam int FW      = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic {S_HDRS, S_BODY} state_t;

  state_t                 state, state_nxt;
  logic [63:0]            ts, ts_lat;
  logic [7:0]             idx;
  logic                   port_hit, probe, stamp_now;
  logic [DATA_WIDTH-1:0]  wr_data;

  logic [FW-1:0]          mem [4];
  logic [1:0]             wr_ptr, rd_ptr;
  logic [2:0]             depth;
  logic                   empty, full, nearly_full, wr_en, rd_en;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_HDRS;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDRS:  if (in_wr && in_ctrl == '0) state_nxt = S_BODY;
      S_BODY:  if (in_wr && in_ctrl != '0) state_nxt = S_HDRS;
      default: state_nxt = S_HDRS;
    endcase
  end

  always_comb begin
    stamp_now = (state == S_BODY) && probe && (idx == 8'(STAMP_WORD));
    wr_data   = stamp_now ? DATA_WIDTH'(ts_lat) : in_data;
  end

  // idx names the word currently on in_data once in BODY; the first body word moves us there
  always_ff @(posedge clk) begin
    if (reset) begin
      port_hit <= 1'b0;
      probe    <= 1'b0;
      idx      <= '0;
      ts_lat   <= '0;
    end else if (in_wr) begin
      if (state == S_HDRS) begin
        if (in_ctrl == IO_QUEUE_STAGE_NUM) begin
          port_hit <= |(in_data[DST_POS+15:DST_POS] & STAMP_PORT_MASK);
          ts_lat   <= ts;
        end else if (in_ctrl == '0) begin
          idx <= 8'd1;
        end
      end else if (in_ctrl != '0) begin
        port_hit <= 1'b0;
        probe    <= 1'b0;
        idx      <= '0;
      end else begin
        if (idx != 8'hff) idx <= idx + 8'd1;
        if (idx == 8'd1)  probe <= port_hit && (in_data[31:16] == PROBE_ETHERTYPE);
      end
    end
  end

  assign empty       = (depth == 3'd0);
  assign full        = (depth == 3'd4);
  assign nearly_full = (depth >= 3'd3);
  assign in_rdy      = !nearly_full;
  assign wr_en       = in_wr && !full;
  assign rd_en       = out_rdy && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 2'd1;
      if (rd_en) rd_ptr <= rd_ptr + 2'd1;
      depth <= depth + {2'b00, wr_en} - {2'b00, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_ctrl, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rd_en) {out_ctrl, out_data} <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) out_wr <= 1'b0;
    else       out_wr <= rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= reg_data_in;
      reg_src_out     <= reg_src_in;
    end
  end

endmodule
